// File: rtl/fantasy_mixer.sv
// fantasy_mixer: per-pixel colour mixer with mode-dependent inversion and a
// frame-paced cross-fade between modes.
//
// Ports:
//   clk_i       pixel clock, all state on rising edge
//   rst_n       asynchronous active-low reset
//   tog_blk_i   one-cycle pulse, toggles block mode
//   tog_inv_i   one-cycle pulse, toggles inversion sense
//   bypass_i    level, forces plain pass-through of pixel data
//   blk_x_i     block-is-bright flag, aligned with data_i
//   hs_i/vs_i/de_i, data_i   input video (channel 0 in LSBs)
//   hs_o/vs_o/de_o, data_o   output video, 2 cycles behind the inputs
//   led_o       {inverted sense, fade in progress, 0, block mode}
//   strength_o  current fade strength s (0 .. 2^SW)
module fantasy_mixer #(
    parameter int CW   = 8,
    parameter int NCH  = 3,
    parameter int SW   = 4,
    parameter int STEP = 4
) (
    input  logic              clk_i,
    input  logic              rst_n,
    input  logic              tog_blk_i,
    input  logic              tog_inv_i,
    input  logic              bypass_i,
    input  logic              blk_x_i,
    input  logic              hs_i,
    input  logic              vs_i,
    input  logic              de_i,
    input  logic [NCH*CW-1:0] data_i,
    output logic              hs_o,
    output logic              vs_o,
    output logic              de_o,
    output logic [NCH*CW-1:0] data_o,
    output logic [3:0]        led_o,
    output logic [SW:0]       strength_o
);

    // Bit 0 = block mode, bit 1 = inverted sense, so each toggle is one XOR.
    typedef enum logic [1:0] {
        DIRECT    = 2'b00,
        BLK_DARK  = 2'b01,
        INV       = 2'b10,
        BLK_LIGHT = 2'b11
    } mode_t;

    typedef enum logic [1:0] {
        STEADY,
        FADE_OUT,
        FADE_IN
    } state_t;

    localparam logic [SW:0]   S_FULL = {1'b1, {SW{1'b0}}};
    localparam logic [SW:0]   S_STEP = (SW+1)'(STEP);

    // Block toggle takes priority when both pulses arrive together.
    function automatic mode_t toggled(input mode_t m, input logic blk);
        return blk ? mode_t'(m ^ 2'b01) : mode_t'(m ^ 2'b10);
    endfunction

    state_t      state;
    mode_t       mode;
    mode_t       pend;
    logic [SW:0] s;
    logic        vs_prev;

    logic        tog;
    logic        frame;
    mode_t       mode_tog;
    mode_t       pend_tog;
    logic [SW:0] s_dn;
    logic [SW:0] s_up;
    logic [SW+1:0] s_sum;

    always_comb begin
        tog      = tog_blk_i | tog_inv_i;
        frame    = vs_i & ~vs_prev;
        mode_tog = toggled(mode, tog_blk_i);
        pend_tog = toggled(pend, tog_blk_i);
        s_dn     = (s > S_STEP) ? s - S_STEP : '0;
        s_sum    = {1'b0, s} + {1'b0, S_STEP};
        s_up     = (s_sum >= {1'b0, S_FULL}) ? S_FULL : s_sum[SW:0];
    end

    // A toggle in the same cycle as a frame event wins; the fade step is
    // simply not taken that cycle.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state   <= STEADY;
            mode    <= BLK_DARK;
            pend    <= BLK_DARK;
            s       <= S_FULL;
            vs_prev <= 1'b0;
        end else begin
            vs_prev <= vs_i;
            case (state)
                STEADY: begin
                    if (tog) begin
                        pend <= mode_tog;
                        if (mode == DIRECT) begin
                            // DIRECT looks the same at any strength, so
                            // commit at once and fade the new mode in.
                            mode  <= mode_tog;
                            s     <= '0;
                            state <= FADE_IN;
                        end else begin
                            state <= FADE_OUT;
                        end
                    end
                end
                FADE_OUT: begin
                    if (tog) begin
                        pend <= pend_tog;
                        if (pend_tog == mode) state <= FADE_IN;
                    end else if (frame) begin
                        if (s_dn == '0) begin
                            mode <= pend;
                            if (pend == DIRECT) begin
                                s     <= S_FULL;
                                state <= STEADY;
                            end else begin
                                s     <= '0;
                                state <= FADE_IN;
                            end
                        end else begin
                            s <= s_dn;
                        end
                    end
                end
                FADE_IN: begin
                    if (tog) begin
                        pend  <= mode_tog;
                        state <= FADE_OUT;
                    end else if (frame) begin
                        s <= s_up;
                        if (s_up == S_FULL) state <= STEADY;
                    end
                end
                default: state <= STEADY;
            endcase
        end
    end

    assign led_o      = {mode[1], (state != STEADY), 1'b0, mode[0]};
    assign strength_o = s;

    // Stage 1: register pixel, inversion decision and strength.
    logic px_inv;
    always_comb begin
        case (mode)
            DIRECT:    px_inv = 1'b0;
            INV:       px_inv = 1'b1;
            BLK_DARK:  px_inv = blk_x_i;
            BLK_LIGHT: px_inv = ~blk_x_i;
            default:   px_inv = 1'b0;
        endcase
        if (bypass_i) px_inv = 1'b0;
    end

    logic [NCH*CW-1:0] d1;
    logic              inv1;
    logic [SW:0]       s1;
    logic [2:0]        sync1;
    logic [NCH*CW-1:0] mix;

    // out = d + floor((~d - d) * s / 2^SW); the result always lies between
    // d and ~d, so truncating the sum to CW bits is exact.
    for (genvar c = 0; c < NCH; c++) begin : g_ch
        logic [CW-1:0]          dc;
        logic signed [CW+1:0]   diff;
        logic signed [CW+SW+3:0] prod;
        always_comb begin
            dc   = d1[c*CW +: CW];
            diff = $signed({2'b00, ~dc}) - $signed({2'b00, dc});
            prod = diff * $signed({1'b0, s1});
        end
        assign mix[c*CW +: CW] = inv1 ? dc + CW'(prod >>> SW) : dc;
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            d1     <= '0;
            inv1   <= 1'b0;
            s1     <= '0;
            sync1  <= '0;
            data_o <= '0;
            hs_o   <= 1'b0;
            vs_o   <= 1'b0;
            de_o   <= 1'b0;
        end else begin
            d1     <= data_i;
            inv1   <= px_inv;
            s1     <= s;
            sync1  <= {vs_i, hs_i, de_i};
            data_o <= mix;
            vs_o   <= sync1[2];
            hs_o   <= sync1[1];
            de_o   <= sync1[0];
        end
    end

endmodule

// File: tb/tb_fantasy_mixer.sv
// Directed bench for fantasy_mixer: streamed vector tables per mode plus
// hand-written fade/toggle/reset sequences.
module tb_fantasy_mixer;

    localparam int CW = 8;
    localparam int NCH = 3;
    localparam int SW = 4;
    localparam int STEP = 4;

    logic              clk_i = 1'b0;
    logic              rst_n;
    logic              tog_blk_i, tog_inv_i, bypass_i, blk_x_i;
    logic              hs_i, vs_i, de_i;
    logic [NCH*CW-1:0] data_i;
    logic              hs_o, vs_o, de_o;
    logic [NCH*CW-1:0] data_o;
    logic [3:0]        led_o;
    logic [SW:0]       strength_o;

    fantasy_mixer #(.CW(CW), .NCH(NCH), .SW(SW), .STEP(STEP)) dut (
        .clk_i(clk_i), .rst_n(rst_n),
        .tog_blk_i(tog_blk_i), .tog_inv_i(tog_inv_i),
        .bypass_i(bypass_i), .blk_x_i(blk_x_i),
        .hs_i(hs_i), .vs_i(vs_i), .de_i(de_i), .data_i(data_i),
        .hs_o(hs_o), .vs_o(vs_o), .de_o(de_o), .data_o(data_o),
        .led_o(led_o), .strength_o(strength_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        blk_x;
        logic        bypass;
        logic [2:0]  sync;   // {vs, hs, de}
        logic [23:0] d;
        logic [23:0] exp_d;
    } vec_t;

    vec_t tv [0:17];
    int   total = 0;
    int   passed = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic pulse(input logic b, input logic i);
        tog_blk_i = b;
        tog_inv_i = i;
        tick();
        tog_blk_i = 1'b0;
        tog_inv_i = 1'b0;
    endtask

    task automatic frame();
        vs_i = 1'b1;
        tick();
        vs_i = 1'b0;
        tick();
    endtask

    // Streams vectors one per cycle; vector k is checked two edges later.
    task automatic run_vecs(input int first, input int last, input logic [SW:0] exp_s);
        for (int j = first; j <= last + 2; j++) begin
            if (j >= first + 2) begin
                chk($sformatf("data[%0d]", j-2), 32'(data_o), 32'(tv[j-2].exp_d));
                chk($sformatf("sync[%0d]", j-2), 32'({vs_o, hs_o, de_o}), 32'(tv[j-2].sync));
                chk($sformatf("strength[%0d]", j-2), 32'(strength_o), 32'(exp_s));
            end
            if (j <= last) begin
                blk_x_i = tv[j].blk_x;
                bypass_i = tv[j].bypass;
                {vs_i, hs_i, de_i} = tv[j].sync;
                data_i = tv[j].d;
            end else begin
                blk_x_i = 1'b0;
                bypass_i = 1'b0;
                {vs_i, hs_i, de_i} = 3'b000;
                data_i = '0;
            end
            tick();
        end
    endtask

    task automatic chk_state(input string name, input logic [SW:0] exp_s, input logic [3:0] exp_led);
        chk({name, " strength"}, 32'(strength_o), 32'(exp_s));
        chk({name, " led"}, 32'(led_o), 32'(exp_led));
    endtask

    initial begin
        // BLK_DARK, s=16
        tv[0]  = '{1'b1, 1'b0, 3'b011, 24'h000000, 24'hFFFFFF};
        tv[1]  = '{1'b0, 1'b0, 3'b010, 24'h000000, 24'h000000};
        tv[2]  = '{1'b1, 1'b0, 3'b101, 24'h000000, 24'hFFFFFF};
        tv[3]  = '{1'b1, 1'b1, 3'b001, 24'h000000, 24'h000000};
        tv[4]  = '{1'b1, 1'b0, 3'b000, 24'h123456, 24'hEDCBA9};
        // BLK_LIGHT, s=16
        tv[5]  = '{1'b0, 1'b0, 3'b011, 24'h00A0FF, 24'hFF5F00};
        tv[6]  = '{1'b1, 1'b0, 3'b001, 24'h00A0FF, 24'h00A0FF};
        tv[7]  = '{1'b0, 1'b1, 3'b010, 24'h00A0FF, 24'h00A0FF};
        // INV, s=16
        tv[8]  = '{1'b0, 1'b0, 3'b011, 24'h202020, 24'hDFDFDF};
        tv[9]  = '{1'b1, 1'b0, 3'b110, 24'h00FF80, 24'hFF007F};
        tv[10] = '{1'b0, 1'b1, 3'b001, 24'h202020, 24'h202020};
        // INV, s=12 (floor of negative products)
        tv[11] = '{1'b0, 1'b0, 3'b001, 24'h0020FF, 24'hBFAF3F};
        tv[12] = '{1'b1, 1'b0, 3'b010, 24'h808080, 24'h7F7F7F};
        tv[13] = '{1'b0, 1'b1, 3'b011, 24'h808080, 24'h808080};
        // INV, s=8
        tv[14] = '{1'b0, 1'b0, 3'b001, 24'h202020, 24'h7F7F7F};
        tv[15] = '{1'b0, 1'b0, 3'b010, 24'hFFFFFF, 24'h7F7F7F};
        tv[16] = '{1'b1, 1'b0, 3'b011, 24'h00FF20, 24'h7F7F7F};
        tv[17] = '{1'b0, 1'b1, 3'b000, 24'h00FF20, 24'h00FF20};

        rst_n = 1'b0;
        tog_blk_i = 1'b0; tog_inv_i = 1'b0; bypass_i = 1'b0; blk_x_i = 1'b0;
        hs_i = 1'b0; vs_i = 1'b0; de_i = 1'b0; data_i = '0;
        tick(); tick();
        chk("reset data", 32'(data_o), 32'h0);
        chk("reset sync", 32'({vs_o, hs_o, de_o}), 32'h0);
        chk_state("reset", 5'd16, 4'b0001);
        rst_n = 1'b1;
        tick();

        run_vecs(0, 4, 5'd16);

        // BLK_DARK -> BLK_LIGHT full fade out / fade in
        pulse(1'b0, 1'b1);
        chk_state("inv start", 5'd16, 4'b0101);
        frame(); chk_state("out1", 5'd12, 4'b0101);
        frame(); chk_state("out2", 5'd8,  4'b0101);
        frame(); chk_state("out3", 5'd4,  4'b0101);
        frame(); chk_state("out4", 5'd0,  4'b1101);
        frame(); chk_state("in1",  5'd4,  4'b1101);
        frame(); chk_state("in2",  5'd8,  4'b1101);
        frame(); chk_state("in3",  5'd12, 4'b1101);
        frame(); chk_state("in4",  5'd16, 4'b1001);

        run_vecs(5, 7, 5'd16);

        // Fade-out reversed at s=8 by a block toggle returning pend to mode
        pulse(1'b1, 1'b0);
        chk_state("blk start", 5'd16, 4'b1101);
        frame(); frame();
        chk_state("blk s8", 5'd8, 4'b1101);
        pulse(1'b1, 1'b0);
        chk_state("reverse", 5'd8, 4'b1101);
        frame(); chk_state("rev up1", 5'd12, 4'b1101);
        frame(); chk_state("rev up2", 5'd16, 4'b1001);

        // Both pulses together: only block toggle, BLK_LIGHT -> INV
        pulse(1'b1, 1'b1);
        chk_state("both start", 5'd16, 4'b1101);
        repeat (4) frame();
        chk_state("both commit", 5'd0, 4'b1100);
        repeat (4) frame();
        chk_state("inv steady", 5'd16, 4'b1000);

        run_vecs(8, 10, 5'd16);

        // INV -> DIRECT fade-out, partial strengths
        pulse(1'b0, 1'b1);
        frame();
        chk_state("inv s12", 5'd12, 4'b1100);
        run_vecs(11, 13, 5'd12);
        frame();
        chk_state("inv s8", 5'd8, 4'b1100);
        run_vecs(14, 17, 5'd8);

        // Toggle coincident with frame event: step skipped, back to FADE_IN
        tog_inv_i = 1'b1;
        vs_i = 1'b1;
        tick();
        tog_inv_i = 1'b0;
        vs_i = 1'b0;
        tick();
        chk_state("tog+frame", 5'd8, 4'b1100);
        frame();
        chk_state("fade in s12", 5'd12, 4'b1100);

        // Asynchronous reset mid-fade with non-zero outputs
        bypass_i = 1'b1; data_i = 24'hFFFFFF; hs_i = 1'b1; de_i = 1'b1;
        tick(); tick();
        chk("pre-reset data", 32'(data_o), 32'hFFFFFF);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async data", 32'(data_o), 32'h0);
        chk("async sync", 32'({vs_o, hs_o, de_o}), 32'h0);
        chk_state("async", 5'd16, 4'b0001);
        bypass_i = 1'b0; data_i = '0; hs_i = 1'b0; de_i = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        frame();
        chk_state("post reset", 5'd16, 4'b0001);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
